seq_divider: RTL and testbench

- Iterative restoring divider; the arithmetic inverse of the team's 8x8 Wallace-tree multiplier.
- Takes a 16-bit dividend (e.g. an accumulated convolution product) and an 8-bit divisor, for normalisation/scaling after the MAC stage.
- Produces one quotient bit per clock.
- Valid/ready handshake on both sides.

---
 rtl/seq_divider_pkg.sv | 11 +
 rtl/seq_divider_div_step.sv | 15 +
 rtl/seq_divider.sv | 111 +++++++++++
 tb/tb_seq_divider.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared state encoding, default widths and counter sizing for seq_divider
package seq_divider_pkg;
  localparam int DIVIDEND_W_DEF = 16;
  localparam int DIVISOR_W_DEF = 8;
  localparam int CNT_W = $clog2(DIVIDEND_W_DEF + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  // Counter width able to hold the value w (one bit per dividend bit plus terminal count)
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one restoring-division iteration (shift in next dividend bit, trial-subtract divisor)
module div_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_rem,
  input  logic         i_bit,
  input  logic [W-1:0] i_div,
  output logic [W-1:0] o_rem,
  output logic         o_q
);
  logic [W:0] w_sh;
  assign w_sh  = {i_rem, i_bit};
  assign o_q   = w_sh >= {1'b0, i_div};
  assign o_rem = o_q ? W'(w_sh - {1'b0, i_div}) : w_sh[W-1:0];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (truncating division, remainder
// carries the dividend sign); otherwise the datapath is purely unsigned.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);
  localparam int CW = cnt_w(DIVIDEND_W);
  state_t                r_state, w_next;
  logic [CW-1:0]         r_cnt;
  logic [DIVIDEND_W-1:0] r_dvd, w_dvd_in, w_quo_fin;
  logic [DIVISOR_W-1:0]  r_dvs, w_dvs_in, r_prem, w_prem, w_rem_fin;
  logic [DIVIDEND_W-1:0] r_quo;
  logic [DIVISOR_W-1:0]  r_rem;
  logic                  r_dbz, w_qbit, w_last, w_zero;
  assign in_ready    = r_state == IDLE;
  assign out_valid   = r_state == DONE;
  assign quotient    = r_quo;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;
  assign w_zero      = divisor == '0;
  assign w_last      = r_cnt == CW'(DIVIDEND_W - 1);
  div_step #(.W(DIVISOR_W)) u_step (
    .i_rem(r_prem),
    .i_bit(r_dvd[DIVIDEND_W-1]),
    .i_div(r_dvs),
    .o_rem(w_prem),
    .o_q  (w_qbit)
  );
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic r_neg_q, r_neg_r;
  assign w_dvd_in = dividend[DIVIDEND_W-1] ? -dividend : dividend;
  assign w_dvs_in = divisor[DIVISOR_W-1] ? -divisor : divisor;
  assign w_quo_fin = r_neg_q ? -{r_dvd[DIVIDEND_W-2:0], w_qbit} : {r_dvd[DIVIDEND_W-2:0], w_qbit};
  assign w_rem_fin = r_neg_r ? -w_prem : w_prem;
  // Capture result sign corrections alongside the operand magnitudes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (r_state == IDLE && in_valid) begin
      r_neg_q <= dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
      r_neg_r <= dividend[DIVIDEND_W-1];
    end
  end
`else
  assign w_dvd_in  = dividend;
  assign w_dvs_in  = divisor;
  assign w_quo_fin = {r_dvd[DIVIDEND_W-2:0], w_qbit};
  assign w_rem_fin = w_prem;
`endif
  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  // Next state: accept in IDLE, iterate DIVIDEND_W edges in RUN, hold DONE until drained
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = in_valid ? (w_zero ? DONE : RUN) : IDLE;
      RUN:     w_next = w_last ? DONE : RUN;
      DONE:    w_next = out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  // Datapath: dividend register doubles as the quotient shift register; results land on RUN->DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_prem <= '0;
      r_quo  <= '0;
      r_rem  <= '0;
      r_dbz  <= 1'b0;
    end else if (r_state == IDLE && in_valid) begin
      r_cnt  <= '0;
      r_dvd  <= w_dvd_in;
      r_dvs  <= w_dvs_in;
      r_prem <= '0;
      r_dbz  <= w_zero;
      if (w_zero) begin
        r_quo <= '1;
        r_rem <= dividend[DIVISOR_W-1:0];
      end
    end else if (r_state == RUN) begin
      r_cnt  <= r_cnt + 1'b1;
      r_dvd  <= {r_dvd[DIVIDEND_W-2:0], w_qbit};
      r_prem <= w_prem;
      if (w_last) begin
        r_quo <= w_quo_fin;
        r_rem <= w_rem_fin;
      end
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed table-driven check of seq_divider plus backpressure and reset sequences
module tb_seq_divider;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;
  int          n_chk = 0;
  int          n_err = 0;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    int          lat;
  } vec_t;

  seq_divider dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one operation; lat counts edges from the accept edge (inclusive) to out_valid
  task automatic do_op(input logic [15:0] a, input logic [7:0] b, output int lat, output logic busy_ok);
    int w = 0;
    while (!in_ready && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    chk("ready_before_op", 32'(in_ready), 32'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = 16'hDEAD;
    divisor  = 8'h00;
    lat = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    vec_t vecs[$];
    int lat;
    logic busy_ok;
`ifdef SEQ_DIVIDER_SIGNED_EN
    vecs.push_back('{16'hFC18, 8'd7,    16'hFF72, 8'hFA, 1'b0, 17});
    vecs.push_back('{16'h8000, 8'hFF,   16'h8000, 8'h00, 1'b0, 17});
    vecs.push_back('{16'd1000, 8'd7,    16'd142,  8'd6,  1'b0, 17});
    vecs.push_back('{16'd1000, 8'hF9,   16'hFF72, 8'd6,  1'b0, 17});
    vecs.push_back('{16'hFC18, 8'hF9,   16'd142,  8'hFA, 1'b0, 17});
    vecs.push_back('{16'h1234, 8'd0,    16'hFFFF, 8'h34, 1'b1, 1});
    vecs.push_back('{16'd10,   8'd3,    16'd3,    8'd1,  1'b0, 17});
    vecs.push_back('{16'd0,    8'd9,    16'd0,    8'd0,  1'b0, 17});
`else
    vecs.push_back('{16'd1000,  8'd7,   16'd142,   8'd6,  1'b0, 17});
    vecs.push_back('{16'd65535, 8'd255, 16'd257,   8'd0,  1'b0, 17});
    vecs.push_back('{16'd65535, 8'd1,   16'd65535, 8'd0,  1'b0, 17});
    vecs.push_back('{16'd5,     8'd200, 16'd0,     8'd5,  1'b0, 17});
    vecs.push_back('{16'd0,     8'd9,   16'd0,     8'd0,  1'b0, 17});
    vecs.push_back('{16'h1234,  8'd0,   16'hFFFF,  8'h34, 1'b1, 1});
    vecs.push_back('{16'd10,    8'd3,   16'd3,     8'd1,  1'b0, 17});
    vecs.push_back('{16'd50000, 8'd123, 16'd406,   8'd62, 1'b0, 17});
`endif
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, lat, busy_ok);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_busy", i), 32'(busy_ok), 32'd1);
      chk($sformatf("v%0d_quotient", i), 32'(quotient), 32'(vecs[i].q));
      chk($sformatf("v%0d_remainder", i), 32'(remainder), 32'(vecs[i].r));
      chk($sformatf("v%0d_dbz", i), 32'(div_by_zero), 32'(vecs[i].dz));
      @(posedge clk); #1;
      chk($sformatf("v%0d_idle_after", i), 32'(in_ready), 32'd1);
      chk($sformatf("v%0d_hold_q", i), 32'(quotient), 32'(vecs[i].q));
    end

    out_ready = 1'b0;
    do_op(16'd1000, 8'd7, lat, busy_ok);
    chk("bp_latency", 32'(lat), 32'd17);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      dividend = 16'd99;
      divisor  = 8'd2;
      @(posedge clk); #1;
      chk($sformatf("bp%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
      chk($sformatf("bp%0d_quotient", k), 32'(quotient), 32'd142);
      chk($sformatf("bp%0d_remainder", k), 32'(remainder), 32'd6);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_quotient", 32'(quotient), 32'd142);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_not_queued", 32'(in_ready), 32'd1);

    dividend = 16'd300;
    divisor  = 8'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("mid_run_busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_quotient", 32'(quotient), 32'd0);
    chk("mid_rst_remainder", 32'(remainder), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_op(16'd300, 8'd7, lat, busy_ok);
    chk("after_rst_latency", 32'(lat), 32'd17);
    chk("after_rst_quotient", 32'(quotient), 32'd42);
    chk("after_rst_remainder", 32'(remainder), 32'd6);
    chk("after_rst_dbz", 32'(div_by_zero), 32'd0);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
